ssp_id_regs: RTL and testbench
==============================

SSP_ID_REGS -- requirements
Module: ssp_id_regs

Interface
REQ-001 Parameters: none; all ID values are fixed constants listed under Function.
REQ-002 PCLK  input  1  APB clock; the single clock of the block.
REQ-003 PRESETn  input  1  reset; asynchronous, active-low.
REQ-004 PSEL  input  1  APB select for the SSP ID window.
REQ-005 PENABLE  input  1  APB access-phase strobe.
REQ-006 PWRITE  input  1  APB direction; 1 = write.
REQ-007 PADDR  input  10  word address PADDR[11:2].
REQ-008 Revision  input  1  revision designator from the tie-off AND cell.
REQ-009 PRDATA  output  32  registered read data; zero when no ID read is selected.
REQ-010 PREADY  output  1  APB ready; low only for wait states defined under Configuration.
REQ-011 RevLocked  output  1  1 once the revision bit has been captured.
REQ-012 RevNibble  output  4  captured revision field {3'b001, RevCapt}.

Function
REQ-013 ID map for byte offsets 0xFE0/FE4/FE8/FEC/FF0/FF4/FF8/FFC: 0x22, 0x10, {RevNibble,4'h4}, 0x00, 0x0D, 0xF0, 0x05, 0xB1, each zero-extended to 32 bits.
REQ-014 Read setup phase is PSEL=1, PENABLE=0, PWRITE=0; the block SHALL register the decoded value into PRDATA on that clock edge, giving zero-wait-state data in the access phase.
REQ-015 PRDATA SHALL hold its value through the access phase and SHALL return to 0 on the first edge with PSEL=0.
REQ-016 Addresses outside 0xFE0-0xFFC, and all writes, SHALL load PRDATA with 0; writes have no other effect.
REQ-017 The capture FSM SHALL have three states: IDLE, SAMPLE and LOCKED.
REQ-018 IDLE SHALL move to SAMPLE on the first edge after reset release.
REQ-019 In SAMPLE a 2-bit counter SHALL count consecutive cycles in which Revision equals the previous sample; any mismatch SHALL clear the counter and the FSM SHALL stay in SAMPLE.
REQ-020 When the counter reaches 3 (four equal samples) the FSM SHALL latch RevCapt, set RevLocked=1 and enter LOCKED.
REQ-021 LOCKED is terminal; later changes on Revision SHALL be ignored until the next PRESETn assertion.
REQ-022 Before lock, RevNibble SHALL read 4'h2 (RevCapt=0).
REQ-023 Minimum latency from reset release to RevLocked=1 is 5 PCLK cycles with a stable Revision.

Reset
REQ-024 PRESETn low SHALL immediately force PRDATA=0, PREADY=1, RevLocked=0, RevCapt=0, counter=0 and FSM=IDLE.
REQ-025 Reset asserted mid-transfer SHALL abort it; after release the block SHALL behave as if no transfer had started.

Configuration
REQ-026 Macro SSP_ID_CAPTURE_WAIT_EN defined: an access phase to offset 0xFE8 while RevLocked=0 SHALL drive PREADY=0 until the cycle RevLocked rises; PRDATA SHALL then be reloaded with the locked value and PREADY driven to 1 in the same cycle.
REQ-027 Macro SSP_ID_CAPTURE_WAIT_EN undefined: PREADY SHALL be tied to 1, and a read of 0xFE8 before lock SHALL return 0x24.

Verification
REQ-028 Revision=1 held, release reset -> RevLocked=1 at cycle 5; read 0xFE8 -> PRDATA=0x34, PREADY=1.
REQ-029 Revision toggles 0,1,0 in SAMPLE, then 1 held -> counter restarts; RevLocked=1 four cycles after the last toggle; RevNibble=4'h3.
REQ-030 Read all eight ID offsets after lock with Revision=0 -> 0x22,0x10,0x24,0x00,0x0D,0xF0,0x05,0xB1; read 0x000 -> 0; write 0xFE0 -> no change, PRDATA=0.
REQ-031 With the macro, read 0xFE8 at cycle 1 after reset -> PREADY=0 until lock, then 0x34 with PREADY=1; without the macro -> 0x24 with no wait.
REQ-032 After lock, Revision changes 1->0 -> RevNibble stays 4'h3; assert PRESETn during an access phase -> PRDATA=0, RevLocked=0 immediately.

Source files
------------

// File: rtl/ssp_id_regs_if.sv
// APB bus bundle for the SSP peripheral ID register window.
// The master drives select, strobe, direction and word address. The slave
// returns read data and ready.
interface ssp_id_regs_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [9:0]  PADDR;
    logic [31:0] PRDATA;
    logic        PREADY;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/ssp_id_regs.sv
// SSP peripheral/cell ID registers (byte offsets 0xFE0-0xFFC).
//
// A small capture FSM samples the tie-off Revision bit after reset. Once
// the bit has been stable for four samples, the FSM locks it in. The
// locked value is reported through the PeriphID2 revision nibble.
//
// Optional build macro SSP_ID_CAPTURE_WAIT_EN: a read of 0xFE8 issued
// before the revision bit is locked is held with wait states. The read
// then completes with the locked value. Without the macro, PREADY is
// always 1 and an early read returns the pre-lock nibble.
module ssp_id_regs (
    input  logic         PCLK,
    input  logic         PRESETn,
    ssp_id_regs_if.slave apb,
    input  logic         Revision,
    output logic         RevLocked,
    output logic [3:0]   RevNibble
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        LOCKED = 2'd2
    } captState_t;

    // Word address of byte offset 0xFE8 (PeriphID2).
    localparam logic [9:0] ID2_WORD = 10'h3FA;

    captState_t  state;
    captState_t  nextState;
    logic [1:0]  sameCnt;
    logic [1:0]  nextCnt;
    logic        prevRev;
    logic        nextPrev;
    logic        revCapt;
    logic        nextCapt;
    logic        lockNow;

    logic        idHit;
    logic [7:0]  idValue;
    logic        readSetup;
    logic        waitAccess;

    assign RevLocked = (state == LOCKED);
    assign RevNibble = {3'b001, revCapt};

    // Capture FSM state and sample registers.
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // updates from the same pre-edge values.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state   <= IDLE;
            sameCnt <= 2'd0;
            prevRev <= 1'b0;
            revCapt <= 1'b0;
        end else begin
            state   <= nextState;
            sameCnt <= nextCnt;
            prevRev <= nextPrev;
            revCapt <= nextCapt;
        end
    end

    // Capture FSM next-state logic: count repeated equal samples, then lock.
    // NOTE: every output gets a default first, so no path can infer a latch.
    always_comb begin
        nextState = state;
        nextCnt   = sameCnt;
        nextPrev  = prevRev;
        nextCapt  = revCapt;
        lockNow   = 1'b0;
        case (state)
            IDLE: begin
                nextState = SAMPLE;
                nextPrev  = Revision;
                nextCnt   = 2'd0;
            end
            SAMPLE: begin
                if (sameCnt == 2'd3) begin
                    nextState = LOCKED;
                    nextCapt  = prevRev;
                    lockNow   = 1'b1;
                end else begin
                    nextPrev = Revision;
                    nextCnt  = (Revision == prevRev) ? sameCnt + 2'd1 : 2'd0;
                end
            end
            LOCKED: begin
                nextState = LOCKED;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // ID map decode for the eight word offsets 0x3F8-0x3FF.
    always_comb begin
        idHit   = (apb.PADDR[9:3] == 7'h7F);
        idValue = 8'h00;
        if (idHit) begin
            case (apb.PADDR[2:0])
                3'd0: idValue = 8'h22;
                3'd1: idValue = 8'h10;
                3'd2: idValue = {RevNibble, 4'h4};
                3'd3: idValue = 8'h00;
                3'd4: idValue = 8'h0D;
                3'd5: idValue = 8'hF0;
                3'd6: idValue = 8'h05;
                3'd7: idValue = 8'hB1;
                default: idValue = 8'h00;
            endcase
        end
    end

    assign readSetup  = apb.PSEL && !apb.PENABLE && !apb.PWRITE;
    assign waitAccess = apb.PSEL && apb.PENABLE && !apb.PWRITE &&
                        (apb.PADDR == ID2_WORD);

`ifdef SSP_ID_CAPTURE_WAIT_EN
    // Stall an early PeriphID2 read until the revision bit is locked.
    // Reset forces ready high regardless of the bus state.
    assign apb.PREADY = !PRESETn || !waitAccess || RevLocked;
`else
    assign apb.PREADY = 1'b1;
`endif

    // Read data register: load in setup, hold in access, clear when idle.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            apb.PRDATA <= 32'h0;
        end else if (!apb.PSEL) begin
            apb.PRDATA <= 32'h0;
        end else if (!apb.PENABLE) begin
            apb.PRDATA <= readSetup ? {24'h0, idValue} : 32'h0;
`ifdef SSP_ID_CAPTURE_WAIT_EN
        end else if (waitAccess && lockNow) begin
            // Reload with the value being locked on this very edge.
            apb.PRDATA <= {24'h0, 3'b001, prevRev, 4'h4};
`endif
        end
    end

endmodule

// File: tb/tb_ssp_id_regs.sv
// Scoreboard bench for ssp_id_regs. Stimulus pushes the expected read
// data per APB transfer, and a negedge monitor pops and compares it when
// the access phase completes. Status outputs are checked directly.
module tb_ssp_id_regs;

    logic       PCLK = 1'b0;
    logic       PRESETn = 1'b0;
    logic       Revision = 1'b0;
    logic       RevLocked;
    logic [3:0] RevNibble;

    ssp_id_regs_if bus ();

    ssp_id_regs dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .apb       (bus.slave),
        .Revision  (Revision),
        .RevLocked (RevLocked),
        .RevNibble (RevNibble)
    );

    always #5 PCLK = ~PCLK;

    int          nChecks = 0;
    int          nFails  = 0;
    logic [31:0] expQ[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Monitor: one completed access phase per negedge with PREADY high.
    always @(negedge PCLK) begin
        if (PRESETn && bus.PSEL && bus.PENABLE && bus.PREADY) begin
            if (expQ.size() == 0) begin
                check("unexpected_xfer", 32'd1, 32'd0);
            end else begin
                check("prdata", bus.PRDATA, expQ.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the completing edge.
    task automatic apbXfer(input logic wr, input logic [9:0] addr,
                           input logic [31:0] exp, output int waits);
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = wr;
        bus.PADDR   = addr;
        expQ.push_back(exp);
        tick(1);
        bus.PENABLE = 1'b1;
        waits = 0;
        @(negedge PCLK);
        while (!bus.PREADY && waits < 50) begin
            waits++;
            @(negedge PCLK);
        end
        if (!bus.PREADY) check("ready_timeout", {31'h0, bus.PREADY}, 32'd1);
        tick(1);
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
    endtask

    // Assert reset with the bus idle, then release just after a rising edge.
    task automatic doReset(input logic rev);
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = 10'h0;
        Revision    = rev;
        PRESETn     = 1'b0;
        #3;
        @(posedge PCLK);
        #1;
        PRESETn = 1'b1;
    endtask

    logic [7:0] idTable [8] = '{8'h22, 8'h10, 8'h24, 8'h00,
                                8'h0D, 8'hF0, 8'h05, 8'hB1};

    initial begin
        int w;

        // Reset values.
        doReset(1'b1);
        PRESETn = 1'b0;
        #1;
        check("rst_prdata", bus.PRDATA, 32'h0);
        check("rst_pready", {31'h0, bus.PREADY}, 32'd1);
        check("rst_locked", {31'h0, RevLocked}, 32'd0);
        check("rst_nibble", {28'h0, RevNibble}, 32'h2);

        // Stable Revision=1: lock appears on the fifth edge after release.
        doReset(1'b1);
        for (int e = 1; e <= 6; e++) begin
            tick(1);
            check($sformatf("lock_edge%0d", e), {31'h0, RevLocked},
                  (e >= 5) ? 32'd1 : 32'd0);
        end
        check("nibble_rev1", {28'h0, RevNibble}, 32'h3);
        apbXfer(1'b0, 10'h3FA, 32'h34, w);
        check("id2_nowait", w, 32'd0);
        check("prdata_hold", bus.PRDATA, 32'h34);
        tick(1);
        check("prdata_idle", bus.PRDATA, 32'h0);

        // Toggling Revision restarts the equal-sample count.
        doReset(1'b0);
        for (int e = 1; e <= 8; e++) begin
            tick(1);
            check($sformatf("toggle_edge%0d", e), {31'h0, RevLocked},
                  (e >= 8) ? 32'd1 : 32'd0);
            if (e == 1) Revision = 1'b1;
            if (e == 2) Revision = 1'b0;
            if (e == 3) Revision = 1'b1;
        end
        check("toggle_nibble", {28'h0, RevNibble}, 32'h3);

        // Revision changes after lock are ignored.
        Revision = 1'b0;
        tick(6);
        check("post_lock_nibble", {28'h0, RevNibble}, 32'h3);
        check("post_lock_locked", {31'h0, RevLocked}, 32'd1);
        apbXfer(1'b0, 10'h3FA, 32'h34, w);

        // Reset asserted during an access phase aborts it at once.
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = 10'h3F8;
        expQ.push_back(32'h22);
        tick(1);
        bus.PENABLE = 1'b1;
        @(negedge PCLK);
        #2;
        PRESETn = 1'b0;
        #1;
        check("abort_prdata", bus.PRDATA, 32'h0);
        check("abort_locked", {31'h0, RevLocked}, 32'd0);
        check("abort_pready", {31'h0, bus.PREADY}, 32'd1);
        check("abort_nibble", {28'h0, RevNibble}, 32'h2);
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        @(posedge PCLK);
        #1;
        PRESETn = 1'b1;
        tick(2);
        check("abort_after", bus.PRDATA, 32'h0);

        // Full ID map after lock with Revision=0, plus misses and a write.
        tick(6);
        check("rev0_locked", {31'h0, RevLocked}, 32'd1);
        check("rev0_nibble", {28'h0, RevNibble}, 32'h2);
        for (int i = 0; i < 8; i++) begin
            apbXfer(1'b0, 10'h3F8 + 10'(i), {24'h0, idTable[i]}, w);
        end
        apbXfer(1'b0, 10'h000, 32'h0, w);
        apbXfer(1'b0, 10'h3F7, 32'h0, w);
        apbXfer(1'b1, 10'h3F8, 32'h0, w);
        check("write_prdata", bus.PRDATA, 32'h0);
        apbXfer(1'b0, 10'h3F8, 32'h22, w);

        // PeriphID2 read issued on the first cycle after reset release.
        doReset(1'b1);
`ifdef SSP_ID_CAPTURE_WAIT_EN
        apbXfer(1'b0, 10'h3FA, 32'h34, w);
        check("early_id2_waits", w, 32'd4);
`else
        apbXfer(1'b0, 10'h3FA, 32'h24, w);
        check("early_id2_waits", w, 32'd0);
`endif

        tick(8);
        check("early_locked", {31'h0, RevLocked}, 32'd1);
        check("queue_drained", expQ.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFails);
        $finish;
    end

endmodule
